// File: rtl/mips_muldiv.sv
// mips_muldiv: MIPS HI/LO unit with iterative shift-add multiply, restoring divide and MTHI/MTLO.
// Define MULDIV_FAST_MULT_EN to make MULT/MULTU single-cycle combinational multiplies.
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0] cnt;
  logic             is_div_q;
  logic             neg_res_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] b_mag_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             dbz_q;

  // Request decode
  logic             is_mul, is_div, is_mt, op_signed, accept, div_zero;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_mt     = (op == OP_MTHI) || (op == OP_MTLO);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign accept    = clk_enable && start && (state == S_IDLE) && (is_mul || is_div || is_mt);
  assign div_zero  = is_div && (op_b == '0);
  assign a_neg     = op_signed && op_a[WIDTH-1];
  assign b_neg     = op_signed && op_b[WIDTH-1];
  // The most-negative value negates to itself, which is its correct unsigned magnitude.
  assign a_mag     = a_neg ? -op_a : op_a;
  assign b_mag     = b_neg ? -op_b : op_b;

  // One iteration of shift-add multiply or restoring divide
  logic [WIDTH:0] mul_sum, div_sh, div_diff;
  logic           div_ge;

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag_q} : '0);
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, b_mag_q};
  assign div_diff = div_sh - {1'b0, b_mag_q};

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_mag = {acc_hi, acc_lo};
  assign prod_fix = neg_res_q ? -prod_mag : prod_mag;
  assign quo_fix  = neg_res_q ? -acc_lo : acc_lo;
  assign rem_fix  = neg_rem_q ? -acc_hi : acc_hi;

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_mag, fast_fix;

  assign fast_mag = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
  assign fast_fix = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           state <= S_IDLE;
    else if (clk_enable) state <= state_nx;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_mt || div_zero) state_nx = S_DONE;
`ifdef MULDIV_FAST_MULT_EN
          else if (is_mul)       state_nx = S_DONE;
`endif
          else                   state_nx = S_RUN;
        end
      end
      S_RUN:   if (cnt == LAST_ITER) state_nx = S_FIX;
      S_FIX:   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_mag_q   <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      dbz_q     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else if (clk_enable) begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt       <= '0;
            is_div_q  <= is_div;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            b_mag_q   <= b_mag;
            acc_hi    <= '0;
            acc_lo    <= a_mag;
            dbz_q     <= div_zero;
            if (op == OP_MTHI) hi <= op_a;
            if (op == OP_MTLO) lo <= op_a;
`ifdef MULDIV_FAST_MULT_EN
            if (is_mul) {hi, lo} <= fast_fix;
`endif
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div_q) begin
            acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (is_div_q) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        S_DONE:  dbz_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy        = (state == S_RUN) || (state == S_FIX);
  assign done        = (state == S_DONE);
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv (WIDTH=32): directed vectors push expected HI/LO/flag/latency,
// a negedge monitor pops and compares on every rising done.
module tb_mips_muldiv;
  localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  typedef struct {
    int          id;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          due;
  } exp_t;

  logic          clk, reset, clk_enable, start;
  logic [2:0]    op;
  logic [W-1:0]  op_a, op_b;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  logic done_prev = 1'b0;
  logic [31:0] m_hi, m_lo;

  mips_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every rising done is matched against the oldest expectation
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("v%0d_hi", e.id), 64'(hi), 64'(e.hi));
        check($sformatf("v%0d_lo", e.id), 64'(lo), 64'(e.lo));
        check($sformatf("v%0d_dbz", e.id), 64'(div_by_zero), 64'(e.dbz));
        check($sformatf("v%0d_latency", e.id), 64'(cyc), 64'(e.due));
      end
    end
    done_prev = done;
  end

  task automatic issue(input int id, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edbz, input int lat);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; op_a = a; op_b = b;
    e.id = id; e.hi = ehi; e.lo = elo; e.dbz = edbz; e.due = cyc + 1 + lat;
    sb.push_back(e);
    m_hi = ehi; m_lo = elo;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d_busy", id), 64'(busy), 64'(lat > 1));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("drain_timeout", 64'(sb.size()), 64'(0));
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = 3'b000; op_a = '0; op_b = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dbz", 64'(div_by_zero), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Multiplies
    issue(1, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, MUL_LAT); drain();
    issue(2, 3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, MUL_LAT); drain();
    issue(3, 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, MUL_LAT); drain();
    issue(4, 3'b000, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, MUL_LAT); drain();

    // Divides
    issue(5, 3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_LAT); drain();
    issue(6, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, DIV_LAT); drain();
    issue(7, 3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, DIV_LAT); drain();
    issue(8, 3'b011, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, 1'b0, DIV_LAT); drain();

    // MTHI, divide by zero keeps HI/LO, MTLO
    issue(9, 3'b100, 32'h1111_1111, 32'h0, 32'h1111_1111, 32'h1999_9999, 1'b0, 0); drain();
    issue(10, 3'b011, 32'h0000_0005, 32'h0, 32'h1111_1111, 32'h1999_9999, 1'b1, 0); drain();
    issue(11, 3'b101, 32'hCAFE_BABE, 32'h0, 32'h1111_1111, 32'hCAFE_BABE, 1'b0, 0); drain();

    // Start held into the DONE cycle of an MTHI must be ignored
    issue(12, 3'b100, 32'h2222_2222, 32'h0, 32'h2222_2222, 32'hCAFE_BABE, 1'b0, 0);
    start = 1'b1; op = 3'b101; op_a = 32'h3333_3333;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_lo", 64'(lo), 64'(32'hCAFE_BABE));
    drain();

    // Illegal op is ignored
    @(negedge clk);
    start = 1'b1; op = 3'b110; op_a = 32'h4444_4444; op_b = 32'h1;
    @(negedge clk);
    start = 1'b0;
    check("illegal_op_busy", 64'(busy), 64'(0));
    check("illegal_op_hi", 64'(hi), 64'(32'h2222_2222));

    // Start while busy is ignored
    issue(13, 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DIV_LAT);
    start = 1'b1; op = 3'b100; op_a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    check("start_busy_hi", 64'(hi), 64'(32'h2222_2222));
    drain();

    // Reset mid-operation aborts, next start accepted
    issue(14, 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DIV_LAT);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    issue(15, 3'b001, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, MUL_LAT); drain();

    // Stalls during RUN extend latency only
    issue(16, 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DIV_LAT + 5);
    for (int s = 0; s < 5; s++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      clk_enable = 1'b0;
      @(negedge clk);
      clk_enable = 1'b1;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
